// File: rtl/cpu_state_sequencer.sv
// Phase sequencer for the multicycle MIPS core: FETCH/EXEC1/EXEC2 strobes, Avalon bus mastering,
// instruction latch with byte-order swap, retired-instruction counter and halt parking.
module cpu_state_sequencer #(
  parameter logic [31:0] INSTR_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        mem_read_req,
  input  logic        mem_write_req,
  input  logic        pc_halt,
  output logic        fetch,
  output logic        exec1,
  output logic        exec2,
  output logic        step,
  output logic        read,
  output logic        write,
  output logic        addr_sel,
  output logic [31:0] instr,
  output logic [31:0] instr_count,
  output logic        active
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC1,
    EXEC2,
    HALTED
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   bus_access;
  logic   exec1_done;

  assign bus_access = mem_read_req | mem_write_req;
  // EXEC1 only waits on the bus when it actually issues an access.
  assign exec1_done = ~(bus_access & waitrequest);

  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    read      = 1'b0;
    write     = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        read = 1'b1;
        step = ~waitrequest;
        if (!waitrequest) state_nxt = EXEC1;
      end
      EXEC1: begin
        write = mem_write_req;
        read  = mem_read_req & ~mem_write_req;
        step  = exec1_done;
        if (exec1_done) state_nxt = EXEC2;
      end
      EXEC2: begin
        step      = 1'b1;
        state_nxt = pc_halt ? HALTED : FETCH;
      end
      HALTED: state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
    if (!reset) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      fetch       <= 1'b0;
      exec1       <= 1'b0;
      exec2       <= 1'b0;
      addr_sel    <= 1'b0;
      active      <= 1'b0;
      instr       <= INSTR_RESET;
      instr_count <= '0;
    end else begin
      state    <= state_nxt;
      fetch    <= (state_nxt == FETCH);
      exec1    <= (state_nxt == EXEC1);
      exec2    <= (state_nxt == EXEC2);
      addr_sel <= (state_nxt == EXEC1);
      active   <= (state_nxt == FETCH) || (state_nxt == EXEC1) || (state_nxt == EXEC2);
      // Bus lanes are little-endian; the decoder expects big-endian instruction words.
      if (state == FETCH && !waitrequest)
        instr <= {readdata[7:0], readdata[15:8], readdata[23:16], readdata[31:24]};
      if (state == EXEC2)
        instr_count <= instr_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Directed + randomized bench for cpu_state_sequencer against a cycle-level phase model.
module tb_cpu_state_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        mem_read_req;
  logic        mem_write_req;
  logic        pc_halt;
  logic        fetch, exec1, exec2, step, read, write, addr_sel, active;
  logic [31:0] instr, instr_count;

  cpu_state_sequencer dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .readdata(readdata),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req), .pc_halt(pc_halt),
    .fetch(fetch), .exec1(exec1), .exec2(exec2), .step(step), .read(read),
    .write(write), .addr_sel(addr_sel), .instr(instr), .instr_count(instr_count),
    .active(active)
  );

  always #5 clk = ~clk;

  localparam int P_IDLE = 0, P_F = 1, P_E1 = 2, P_E2 = 3, P_HALT = 4;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          mphase;
  logic [31:0] minstr;
  logic [31:0] mcount;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] byteswap(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
    return r;
  endfunction

  // One clock cycle: apply inputs, compare outputs mid-cycle, advance the model on the edge.
  task automatic tick(input logic rst, input logic w, input logic rr, input logic wr,
                      input logic h, input logic [31:0] rd);
    logic acc;
    logic exp_step, exp_read, exp_write;
    reset = rst; waitrequest = w; mem_read_req = rr; mem_write_req = wr;
    pc_halt = h; readdata = rd;
    acc       = rr | wr;
    exp_read  = (mphase == P_F) || (mphase == P_E1 && rr && !wr);
    exp_write = (mphase == P_E1) && wr;
    exp_step  = (mphase == P_F && !w) || (mphase == P_E1 && !(acc && w)) || (mphase == P_E2);
    @(negedge clk);
    chk("fetch", fetch, 32'(mphase == P_F));
    chk("exec1", exec1, 32'(mphase == P_E1));
    chk("exec2", exec2, 32'(mphase == P_E2));
    chk("addr_sel", addr_sel, 32'(mphase == P_E1));
    chk("active", active, 32'(mphase >= P_F && mphase <= P_E2));
    chk("step", step, 32'(exp_step));
    chk("read", read, 32'(exp_read));
    chk("write", write, 32'(exp_write));
    chk("instr", instr, minstr);
    chk("instr_count", instr_count, mcount);
    @(posedge clk);
    if (!rst) begin
      mphase = P_IDLE; minstr = 32'h0; mcount = 32'h0;
    end else begin
      case (mphase)
        P_IDLE: mphase = P_F;
        P_F:    if (!w) begin minstr = byteswap(rd); mphase = P_E1; end
        P_E1:   if (!(acc && w)) mphase = P_E2;
        P_E2:   begin mcount = mcount + 32'd1; mphase = h ? P_HALT : P_F; end
        default: mphase = P_HALT;
      endcase
    end
    #1;
  endtask

  initial begin
    int guard;
    reset = 1'b0; waitrequest = 1'b0; readdata = '0;
    mem_read_req = 1'b0; mem_write_req = 1'b0; pc_halt = 1'b0;
    @(posedge clk);
    mphase = P_IDLE; minstr = 32'h0; mcount = 32'h0;
    #1;

    // reset state held for a few cycles
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    chk("rst_instr", instr, 32'h0);
    chk("rst_count", instr_count, 32'h0);

    // release: IDLE then three stall-free instructions
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    chk("fetch_after_release", fetch, 32'h1);
    repeat (9) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    chk("count_after_9", instr_count, 32'd3);

    // fetch stretched by two wait cycles
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h78563412);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h78563412);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h78563412);
    chk("instr_swap", instr, 32'h12345678);

    // EXEC1 load with one wait cycle
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, $urandom);
    chk("exec1_stalled", exec1, 32'h1);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, $urandom);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    // EXEC1 with both requests: write wins
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, $urandom);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    // EXEC1 without access ignores waitrequest
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, $urandom);
    chk("exec1_noacc_exit", exec2, 32'h1);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);

    // halt on the 5th instruction
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    guard = 0;
    while (mphase != P_HALT && guard < 200) begin
      tick(1'b1, ($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           (mphase == P_E2 && mcount == 32'd4), $urandom);
      guard++;
    end
    chk("halt_reached", 32'(mphase == P_HALT), 32'h1);
    chk("halt_count", instr_count, 32'd5);
    chk("halt_active", active, 32'h0);
    repeat (20) tick(1'b1, $urandom_range(0, 1), 1'b0, 1'b0, 1'b0, $urandom);

    // reset during a fetch stall
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, $urandom);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom);
    chk("abort_read", read, 32'h0);
    chk("abort_fetch", fetch, 32'h0);
    chk("abort_count", instr_count, 32'h0);
    repeat (7) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
    chk("restart_count", instr_count, 32'd2);

    // randomized traffic with occasional halts and resets
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0),
           $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 11) == 0), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
